// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared types and constants for the UDP/IP transmit scheduler
package eth_tx_pkg;

  // Scheduler FSM states, in frame order
  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    WAIT_ETH,
    WAIT_IP,
    WAIT_UDP,
    WAIT_PAY,
    IFG
  } sched_state_t;

  // Smallest legal UDP length is a bare 8-byte header
  localparam int UDP_HDR_LEN = 8;
  localparam int IP_HDR_LEN  = 20;
  localparam int IFG_BYTES   = 12;

endpackage

// File: rtl/udp_tx_scheduler_if.sv
// rtl/udp_tx_scheduler_if.sv - requester, header-stage and status signals of the tx scheduler
interface udp_tx_scheduler_if #(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]    req;
  logic [N_REQ*32-1:0] req_ip_d_addr;
  logic [N_REQ*16-1:0] req_udp_len;
  logic [N_REQ-1:0]    grant;
  logic [N_REQ-1:0]    done;
  logic [N_REQ-1:0]    drop;
  logic                tx_start;
  logic [31:0]         ip_d_addr;
  logic [15:0]         udp_len;
  logic                eth_header_ip_tx_done;
  logic                ip_header_tx_done;
  logic                udp_header_tx_done;
  logic                payload_tx_done;
  logic                busy;
  logic                tx_error;

  // Scheduler side
  modport master (
    input  req, req_ip_d_addr, req_udp_len,
    input  eth_header_ip_tx_done, ip_header_tx_done, udp_header_tx_done, payload_tx_done,
    output grant, done, drop, tx_start, ip_d_addr, udp_len, busy, tx_error
  );

  // Requester / header-chain side
  modport slave (
    output req, req_ip_d_addr, req_udp_len,
    output eth_header_ip_tx_done, ip_header_tx_done, udp_header_tx_done, payload_tx_done,
    input  grant, done, drop, tx_start, ip_d_addr, udp_len, busy, tx_error
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner pick starting at the pointer
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Lowest set index at/above ptr wins; otherwise wrap to lowest set index below ptr
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j] && (IDX_W'(j) < ptr)) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req[j] && (IDX_W'(j) >= ptr)) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/udp_tx_scheduler.sv
// rtl/udp_tx_scheduler.sv - round-robin owner of the eth/ip/udp/payload tx chain; optional watchdog via UDP_TX_SCHED_TIMEOUT_EN
module udp_tx_scheduler
  import eth_tx_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int IFG_CYCLES  = IFG_BYTES,
  parameter int MAX_UDP_LEN = 1480,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic             aclk,
  input logic             aresetn,
  udp_tx_scheduler_if.master bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = 13;
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_CYCLES - 1);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] drop_q, drop_d;
  logic [31:0]      ip_q, ip_d;
  logic [15:0]      len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             arb_valid;
  logic [IDX_W-1:0] arb_idx;
  logic [31:0]      win_ip;
  logic [15:0]      win_len;
  logic             len_bad;
  logic             stage_done;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] i);
    next_ptr = (i == IDX_W'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // Pick the winner's destination IP and length out of the flat request buses
  always_comb begin
    win_ip  = '0;
    win_len = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (IDX_W'(j) == arb_idx) begin
        win_ip  = bus.req_ip_d_addr[32*j +: 32];
        win_len = bus.req_udp_len[16*j +: 16];
      end
    end
    len_bad = (win_len < 16'(UDP_HDR_LEN)) || (win_len > 16'(MAX_UDP_LEN));
  end

  // Only the done pulse belonging to the current wait state may advance the FSM
  always_comb begin
    stage_done = 1'b0;
    case (state_q)
      WAIT_ETH: stage_done = bus.eth_header_ip_tx_done;
      WAIT_IP:  stage_done = bus.ip_header_tx_done;
      WAIT_UDP: stage_done = bus.udp_header_tx_done;
      WAIT_PAY: stage_done = bus.payload_tx_done;
      default:  stage_done = 1'b0;
    endcase
  end

`ifdef UDP_TX_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic tx_error_q, tx_error_d;
`endif

  // Next-state and datapath logic for arbitration, stage tracking and gap timing
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    done_d  = '0;
    drop_d  = '0;
    ip_d    = ip_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
`ifdef UDP_TX_SCHED_TIMEOUT_EN
    tx_error_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) state_d = ARB;
      end
      ARB: begin
        state_d = IDLE;
        if (arb_valid) begin
          idx_d = arb_idx;
          ip_d  = win_ip;
          len_d = win_len;
          if (len_bad) begin
            drop_d = onehot(arb_idx);
            ptr_d  = next_ptr(arb_idx);
          end else begin
            grant_d = onehot(arb_idx);
            state_d = START;
          end
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_ETH;
      end
      WAIT_ETH, WAIT_IP, WAIT_UDP, WAIT_PAY: begin
        if (stage_done) begin
          cnt_d = '0;
          case (state_q)
            WAIT_ETH: state_d = WAIT_IP;
            WAIT_IP:  state_d = WAIT_UDP;
            WAIT_UDP: state_d = WAIT_PAY;
            default: begin
              done_d  = grant_q;
              grant_d = '0;
              ptr_d   = next_ptr(idx_q);
              state_d = IFG;
            end
          endcase
        end
`ifdef UDP_TX_SCHED_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          tx_error_d = 1'b1;
          grant_d    = '0;
          ptr_d      = next_ptr(idx_q);
          cnt_d      = '0;
          state_d    = IFG;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      IFG: begin
        if (cnt_q == IFG_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      drop_q  <= '0;
      ip_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      ip_q    <= ip_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef UDP_TX_SCHED_TIMEOUT_EN
  // Watchdog abort pulse register
  always_ff @(posedge aclk) begin
    if (!aresetn) tx_error_q <= 1'b0;
    else          tx_error_q <= tx_error_d;
  end
  assign bus.tx_error = tx_error_q;
`else
  assign bus.tx_error = 1'b0;
`endif

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.drop      = drop_q;
  assign bus.tx_start  = (state_q == START);
  assign bus.ip_d_addr = ip_q;
  assign bus.udp_len   = len_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb/tb_udp_tx_scheduler.sv - directed self-checking bench for udp_tx_scheduler
module tb_udp_tx_scheduler;

  localparam int N = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n_start = 0;
  int   n_done = 0;

  udp_tx_scheduler_if #(.N_REQ(N)) bus ();

  udp_tx_scheduler #(
    .N_REQ       (N),
    .IFG_CYCLES  (12),
    .MAX_UDP_LEN (1480),
    .TIMEOUT_CYC (4096)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (bus.tx_start) n_start++;
    if (|bus.done) n_done++;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [31:0] ip, input logic [15:0] len);
    bus.req_ip_d_addr[32*i +: 32] = ip;
    bus.req_udp_len[16*i +: 16]   = len;
  endtask

  task automatic pulse(input int s);
    case (s)
      0: bus.eth_header_ip_tx_done = 1'b1;
      1: bus.ip_header_tx_done     = 1'b1;
      2: bus.udp_header_tx_done    = 1'b1;
      default: bus.payload_tx_done = 1'b1;
    endcase
    tick();
    bus.eth_header_ip_tx_done = 1'b0;
    bus.ip_header_tx_done     = 1'b0;
    bus.udp_header_tx_done    = 1'b0;
    bus.payload_tx_done       = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      if (bus.tx_start === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    bus.req = '0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    tick();
    tick();
    total++; if ({bus.grant, bus.done, bus.drop} !== 12'h0) begin bad++; $display("FAIL reset_grant_done_drop got=%h want=000", {bus.grant, bus.done, bus.drop}); end
    total++; if ({bus.tx_start, bus.tx_error, bus.busy} !== 3'b000) begin bad++; $display("FAIL reset_start_err_busy got=%b want=000", {bus.tx_start, bus.tx_error, bus.busy}); end
    total++; if ({bus.ip_d_addr, bus.udp_len} !== 48'h0) begin bad++; $display("FAIL reset_ip_len got=%h want=0", {bus.ip_d_addr, bus.udp_len}); end
    aresetn = 1'b1;
  endtask

  task automatic test_single();
    int nb;
    set_src(0, 32'hC0A80002, 16'd100);
    bus.req = 4'b0001;
    tick();
    total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL single_start_early got=%b want=0", bus.tx_start); end
    tick();
    total++; if (bus.tx_start !== 1'b1) begin bad++; $display("FAIL single_start_latency got=%b want=1", bus.tx_start); end
    total++; if (bus.grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", bus.grant); end
    total++; if (bus.ip_d_addr !== 32'hC0A80002) begin bad++; $display("FAIL single_ip got=%h want=c0a80002", bus.ip_d_addr); end
    total++; if (bus.udp_len !== 16'd100) begin bad++; $display("FAIL single_len got=%0d want=100", bus.udp_len); end
    tick();
    total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL single_start_width got=%b want=0", bus.tx_start); end
    pulse(0);
    pulse(1);
    pulse(2);
    total++; if (bus.done !== 4'b0000) begin bad++; $display("FAIL single_done_early got=%b want=0000", bus.done); end
    bus.req = 4'b0000;
    pulse(3);
    total++; if (bus.done !== 4'b0001) begin bad++; $display("FAIL single_done got=%b want=0001", bus.done); end
    total++; if (bus.grant !== 4'b0000) begin bad++; $display("FAIL single_grant_clear got=%b want=0000", bus.grant); end
    nb = 0;
    for (int k = 0; k < 11; k++) begin
      tick();
      if (bus.busy === 1'b1) nb++;
    end
    total++; if (nb !== 11) begin bad++; $display("FAIL single_ifg_busy got=%0d want=11", nb); end
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_ifg_end got=%b want=0", bus.busy); end
    total++; if ({bus.ip_d_addr, bus.udp_len} !== {32'hC0A80002, 16'd100}) begin bad++; $display("FAIL single_hold got=%h want=c0a800020064", {bus.ip_d_addr, bus.udp_len}); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int s0;
    int exp;
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, 32'h0A000000 + 32'(i), 16'(20 + i));
    s0 = n_start;
    bus.req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp = f % N;
      wait_start(ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_start_timeout frame=%0d got=none want=tx_start", f); end
      total++; if (bus.grant !== 4'(1 << exp)) begin bad++; $display("FAIL rr_grant frame=%0d got=%b want=%b", f, bus.grant, 4'(1 << exp)); end
      total++; if (bus.udp_len !== 16'(20 + exp)) begin bad++; $display("FAIL rr_len frame=%0d got=%0d want=%0d", f, bus.udp_len, 20 + exp); end
      tick();
      pulse(0);
      pulse(1);
      pulse(2);
      pulse(3);
      total++; if (bus.done !== 4'(1 << exp)) begin bad++; $display("FAIL rr_done frame=%0d got=%b want=%b", f, bus.done, 4'(1 << exp)); end
    end
    bus.req = 4'b0000;
    for (int k = 0; k < 14; k++) tick();
    total++; if (n_start - s0 !== 5) begin bad++; $display("FAIL rr_start_count got=%0d want=5", n_start - s0); end
  endtask

  task automatic test_drop();
    bit ok;
    int s0;
    do_reset();
    s0 = n_start;
    set_src(2, 32'h01020304, 16'd7);
    bus.req = 4'b0100;
    tick();
    tick();
    total++; if (bus.drop !== 4'b0100) begin bad++; $display("FAIL drop_short got=%b want=0100", bus.drop); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL drop_short_idle got=%b want=0", bus.busy); end
    bus.req = 4'b0000;
    tick();
    total++; if (bus.drop !== 4'b0000) begin bad++; $display("FAIL drop_pulse_width got=%b want=0000", bus.drop); end
    set_src(2, 32'h01020304, 16'd1481);
    bus.req = 4'b0100;
    tick();
    tick();
    total++; if (bus.drop !== 4'b0100) begin bad++; $display("FAIL drop_long got=%b want=0100", bus.drop); end
    bus.req = 4'b0000;
    tick();
    total++; if (n_start !== s0) begin bad++; $display("FAIL drop_no_start got=%0d want=%0d", n_start, s0); end
    set_src(1, 32'h0B000001, 16'd1480);
    set_src(3, 32'h0B000003, 16'd8);
    bus.req = 4'b1010;
    wait_start(ok);
    total++; if (!ok || bus.grant !== 4'b1000) begin bad++; $display("FAIL drop_ptr_adv got=%b want=1000", bus.grant); end
    total++; if (bus.udp_len !== 16'd8) begin bad++; $display("FAIL drop_min_len got=%0d want=8", bus.udp_len); end
    tick();
    pulse(0);
    pulse(1);
    pulse(2);
    bus.req = 4'b0010;
    pulse(3);
    wait_start(ok);
    total++; if (!ok || bus.grant !== 4'b0010) begin bad++; $display("FAIL drop_next_grant got=%b want=0010", bus.grant); end
    total++; if (bus.udp_len !== 16'd1480) begin bad++; $display("FAIL drop_max_len got=%0d want=1480", bus.udp_len); end
    tick();
    pulse(0);
    pulse(1);
    pulse(2);
    bus.req = 4'b0000;
    pulse(3);
    for (int k = 0; k < 14; k++) tick();
  endtask

  task automatic test_out_of_order();
    bit ok;
    int d0;
    do_reset();
    set_src(0, 32'h0C000000, 16'd64);
    bus.req = 4'b0001;
    wait_start(ok);
    tick();
    d0 = n_done;
    pulse(1);
    pulse(2);
    pulse(3);
    total++; if (n_done !== d0 || bus.busy !== 1'b1) begin bad++; $display("FAIL ooo_ignored done_cnt=%0d want=%0d busy=%b", n_done, d0, bus.busy); end
    pulse(0);
    pulse(1);
    pulse(2);
    total++; if (n_done !== d0) begin bad++; $display("FAIL ooo_early_done got=%0d want=%0d", n_done, d0); end
    bus.req = 4'b0000;
    pulse(3);
    total++; if (bus.done !== 4'b0001) begin bad++; $display("FAIL ooo_done got=%b want=0001", bus.done); end
    for (int k = 0; k < 14; k++) tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d0;
    do_reset();
    set_src(0, 32'h0D000000, 16'd200);
    bus.req = 4'b0001;
    wait_start(ok);
    tick();
    pulse(0);
    pulse(1);
    d0 = n_done;
    aresetn = 1'b0;
    tick();
    total++; if ({bus.grant, bus.done, bus.drop, bus.tx_start, bus.busy} !== 14'h0) begin bad++; $display("FAIL midrst_ctrl got=%h want=0", {bus.grant, bus.done, bus.drop, bus.tx_start, bus.busy}); end
    total++; if ({bus.ip_d_addr, bus.udp_len} !== 48'h0) begin bad++; $display("FAIL midrst_data got=%h want=0", {bus.ip_d_addr, bus.udp_len}); end
    bus.req = 4'b0000;
    pulse(3);
    aresetn = 1'b1;
    tick();
    tick();
    total++; if (n_done !== d0 || bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_no_done done_cnt=%0d want=%0d busy=%b", n_done, d0, bus.busy); end
  endtask

`ifdef UDP_TX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int cyc;
    do_reset();
    set_src(0, 32'h0E000000, 16'd30);
    set_src(1, 32'h0E000001, 16'd31);
    bus.req = 4'b0011;
    wait_start(ok);
    tick();
    pulse(0);
    pulse(1);
    pulse(2);
    bus.req = 4'b0010;
    cyc = 0;
    while (bus.tx_error !== 1'b1 && cyc < 5000) begin
      tick();
      cyc++;
    end
    total++; if (cyc !== 4096) begin bad++; $display("FAIL to_cycles got=%0d want=4096", cyc); end
    total++; if (bus.grant !== 4'b0000 || bus.done !== 4'b0000) begin bad++; $display("FAIL to_grant_done grant=%b done=%b want=0000", bus.grant, bus.done); end
    wait_start(ok);
    total++; if (!ok || bus.grant !== 4'b0010) begin bad++; $display("FAIL to_next got=%b want=0010", bus.grant); end
    bus.req = 4'b0000;
  endtask
`endif

  initial begin
    bus.req                   = '0;
    bus.req_ip_d_addr         = '0;
    bus.req_udp_len           = '0;
    bus.eth_header_ip_tx_done = 1'b0;
    bus.ip_header_tx_done     = 1'b0;
    bus.udp_header_tx_done    = 1'b0;
    bus.payload_tx_done       = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_out_of_order();
    test_reset_mid();
`ifdef UDP_TX_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
